// File: rtl/hilo_muldiv_if.sv
// Command/result bundle between the execute-stage control and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;
    logic        active;
    logic        waitrequest;
    logic [1:0]  state;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [31:0] op1;
    logic [31:0] reg_t;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (
        output active, waitrequest, state, opcode, func, op1, reg_t,
        input  hi, lo, busy, done
    );

    modport slave (
        input  active, waitrequest, state, opcode, func, op1, reg_t,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative 32-cycle multiply/divide unit owning the HI/LO registers.
// Handles MULT/MULTU/DIV/DIVU (shift-add and restoring divide) plus MTHI/MTLO.
module hilo_muldiv (
    input  logic          clk,
    input  logic          reset,
    hilo_muldiv_if.slave  bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned CW = 5;

    localparam logic [5:0] FUNC_MTHI  = 6'd17;
    localparam logic [5:0] FUNC_MTLO  = 6'd19;
    localparam logic [5:0] FUNC_MULT  = 6'd24;
    localparam logic [5:0] FUNC_MULTU = 6'd25;
    localparam logic [5:0] FUNC_DIV   = 6'd26;
    localparam logic [5:0] FUNC_DIVU  = 6'd27;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]  acc_q, acc_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   op1_q, op1_d;
    logic           is_div_q, is_div_d;
    logic           neg_q, neg_d;
    logic           rneg_q, rneg_d;
    logic           dz_q, dz_d;

    logic           cmd_ok_c;
    logic           sgn_c, div_c;
    logic [W-1:0]   a_abs_c, b_abs_c;
    logic [W:0]     mul_sum_c;
    logic [W:0]     div_shift_c;
    logic           div_ge_c;
    logic [W-1:0]   div_rem_c;
    logic [AW-1:0]  prod_c;

    assign cmd_ok_c = bus.active && !bus.waitrequest && (bus.state == 2'd1)
                    && (bus.opcode == 6'd0) && !busy_q;

    // Operand preparation: signed ops work on magnitudes, signs are re-applied at FIN.
    assign sgn_c   = (bus.func == FUNC_MULT) || (bus.func == FUNC_DIV);
    assign div_c   = (bus.func == FUNC_DIV) || (bus.func == FUNC_DIVU);
    assign a_abs_c = (sgn_c && bus.op1[W-1])   ? W'(-bus.op1)   : bus.op1;
    assign b_abs_c = (sgn_c && bus.reg_t[W-1]) ? W'(-bus.reg_t) : bus.reg_t;

    // One iteration of each algorithm; acc low half holds multiplier / dividend-quotient.
    assign mul_sum_c   = acc_q[0] ? ({1'b0, acc_q[AW-1:W]} + {1'b0, opnd_q})
                                  : {1'b0, acc_q[AW-1:W]};
    assign div_shift_c = {acc_q[AW-1:W], acc_q[W-1]};
    assign div_ge_c    = div_shift_c >= {1'b0, opnd_q};
    assign div_rem_c   = div_ge_c ? W'(div_shift_c - {1'b0, opnd_q}) : W'(div_shift_c);
    assign prod_c      = neg_q ? AW'(-acc_q) : acc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            op1_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            op1_q    <= op1_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dz_q     <= dz_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        op1_d    = op1_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dz_d     = dz_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_ok_c) begin
                    case (bus.func)
                        FUNC_MTHI: hi_d = bus.op1;
                        FUNC_MTLO: lo_d = bus.op1;
                        FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU: begin
                            is_div_d = div_c;
                            neg_d    = sgn_c && (bus.op1[W-1] ^ bus.reg_t[W-1]);
                            rneg_d   = sgn_c && bus.op1[W-1];
                            dz_d     = (bus.reg_t == '0);
                            op1_d    = bus.op1;
                            opnd_d   = div_c ? b_abs_c : a_abs_c;
                            acc_d    = {{W{1'b0}}, (div_c ? a_abs_c : b_abs_c)};
                            cnt_d    = '0;
                            busy_d   = 1'b1;
                            state_d  = S_RUN;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? {div_rem_c, acc_q[W-2:0], div_ge_c}
                                 : {mul_sum_c, acc_q[W-1:1]};
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (!is_div_q) begin
                    hi_d = prod_c[AW-1:W];
                    lo_d = prod_c[W-1:0];
                end else if (dz_q) begin
                    hi_d = op1_q;
                    lo_d = {W{1'b1}};
                end else begin
                    lo_d = neg_q  ? W'(-acc_q[W-1:0])  : acc_q[W-1:0];
                    hi_d = rneg_q ? W'(-acc_q[AW-1:W]) : acc_q[AW-1:W];
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed-vector bench for hilo_muldiv: arithmetic results, latency, gating and reset abort.
module tb_hilo_muldiv;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    hilo_muldiv_if bus ();

    hilo_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present a command for one accept edge, then scramble operands to prove they were latched.
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.func  = f;
        bus.op1   = a;
        bus.reg_t = b;
        @(posedge clk);
        #1;
        bus.func  = 6'd0;
        bus.op1   = 32'h5A5A_0F0F;
        bus.reg_t = 32'h0000_0003;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.busy && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int n;
        issue(f, a, b);
        check($sformatf("%s.busy_start", tag), 32'(bus.busy), 32'd1);
        wait_done(n);
        check($sformatf("%s.cycles", tag), 32'(n), 32'd33);
        check($sformatf("%s.done", tag), 32'(bus.done), 32'd1);
        check($sformatf("%s.hi", tag), bus.hi, eh);
        check($sformatf("%s.lo", tag), bus.lo, el);
        @(posedge clk);
        #1;
        check($sformatf("%s.done_clr", tag), 32'(bus.done), 32'd0);
    endtask

    initial begin
        int n;
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.active       = 1'b1;
        bus.waitrequest  = 1'b0;
        bus.state        = 2'd1;
        bus.opcode       = 6'd0;
        bus.func         = 6'd0;
        bus.op1          = '0;
        bus.reg_t        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.hi", bus.hi, 32'h0);
        check("rst.lo", bus.lo, 32'h0);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.done", 32'(bus.done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  F_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("div_neg",   F_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negd",  F_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
        run_op("divu",      F_DIVU,  32'd100,       32'd7,         32'd2,         32'd14);
        run_op("divu_z",    F_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF);
        run_op("div_z",     F_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("div_ovf",   F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);

        issue(F_MTLO, 32'h1234_5678, 32'h0);
        check("mtlo.lo", bus.lo, 32'h1234_5678);
        check("mtlo.busy", 32'(bus.busy), 32'd0);
        check("mtlo.done", 32'(bus.done), 32'd0);
        issue(F_MTHI, 32'hCAFE_F00D, 32'h0);
        check("mthi.hi", bus.hi, 32'hCAFE_F00D);

        // MTHI while a multiply is in flight must be dropped.
        issue(F_MULTU, 32'd2, 32'd3);
        @(negedge clk);
        bus.func = F_MTHI;
        bus.op1  = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        bus.func = 6'd0;
        check("busy_mthi.hi", bus.hi, 32'hCAFE_F00D);
        check("busy_mthi.busy", 32'(bus.busy), 32'd1);
        wait_done(n);
        check("busy_mthi.cycles", 32'(n), 32'd32);
        check("busy_mthi.res_hi", bus.hi, 32'h0);
        check("busy_mthi.res_lo", bus.lo, 32'd6);

        // Each gating condition alone must block acceptance.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.func  = F_MULTU;
            bus.op1   = 32'd3;
            bus.reg_t = 32'd4;
            case (i)
                0: bus.waitrequest = 1'b1;
                1: bus.active      = 1'b0;
                2: bus.state       = 2'd2;
                default: bus.opcode = 6'd1;
            endcase
            @(posedge clk);
            #1;
            check($sformatf("gate%0d.busy", i), 32'(bus.busy), 32'd0);
            bus.func        = 6'd0;
            bus.waitrequest = 1'b0;
            bus.active      = 1'b1;
            bus.state       = 2'd1;
            bus.opcode      = 6'd0;
        end
        check("gate.lo_kept", bus.lo, 32'd6);

        // Reset at iteration 10 aborts without writing a result.
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort.hi", bus.hi, 32'h0);
        check("abort.lo", bus.lo, 32'h0);
        check("abort.busy", 32'(bus.busy), 32'd0);
        check("abort.done", 32'(bus.done), 32'd0);
        run_op("after_abort", F_MULTU, 32'd3, 32'd4, 32'h0, 32'd12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
